// File: rtl/app_lock_controller.sv
// Sequential passcode lock: serial digit entry, registered compare, attempt counting
// with timed lockout, and in-place reprogramming of the stored code while unlocked.
module app_lock_controller #(
    parameter int unsigned DIGIT_W        = 4,
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16,
    parameter int unsigned UNLOCK_CYCLES  = 8,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = {4'd5, 4'd6, 4'd7, 4'd8}
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [DIGIT_W-1:0]                      digit_in,
    input  logic                                    digit_valid,
    input  logic                                    enter,
    input  logic                                    clear,
    input  logic                                    set_req,
    output logic                                    unlocked,
    output logic                                    locked_out,
    output logic                                    programming,
    output logic                                    fail,
    output logic                                    prog_done,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]       attempts_left,
    output logic [$clog2(NUM_DIGITS+1)-1:0]         digit_count
);

    localparam int unsigned CODE_W  = NUM_DIGITS * DIGIT_W;
    localparam int unsigned AT_W    = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned DC_W    = $clog2(NUM_DIGITS + 1);
    localparam int unsigned TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_ENTRY    = 3'd0,
        S_CHECK    = 3'd1,
        S_UNLOCKED = 3'd2,
        S_LOCKOUT  = 3'd3,
        S_PROGRAM  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   buf_q, buf_d, buf_wr;
    logic [DC_W-1:0]     count_q, count_d;
    logic [AT_W-1:0]     attempts_q, attempts_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                match_q, match_d;
    logic                full_c;
    logic                unlocked_d, locked_out_d, programming_d, fail_d, prog_done_d;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_ENTRY;
            code_q      <= DEFAULT_CODE;
            buf_q       <= '0;
            count_q     <= '0;
            attempts_q  <= AT_W'(MAX_ATTEMPTS);
            tmr_q       <= '0;
            match_q     <= 1'b0;
            unlocked    <= 1'b0;
            locked_out  <= 1'b0;
            programming <= 1'b0;
            fail        <= 1'b0;
            prog_done   <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            buf_q       <= buf_d;
            count_q     <= count_d;
            attempts_q  <= attempts_d;
            tmr_q       <= tmr_d;
            match_q     <= match_d;
            unlocked    <= unlocked_d;
            locked_out  <= locked_out_d;
            programming <= programming_d;
            fail        <= fail_d;
            prog_done   <= prog_done_d;
        end
    end

    assign attempts_left = attempts_q;
    assign digit_count   = count_q;
    assign full_c        = (count_q == DC_W'(NUM_DIGITS));

    // Buffer image with digit_in placed at the current fill position (first digit in MSBs)
    always_comb begin
        buf_wr = buf_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (count_q == DC_W'(i)) begin
                buf_wr[(int'(NUM_DIGITS) - 1 - i) * int'(DIGIT_W) +: DIGIT_W] = digit_in;
            end
        end
    end

    // Next-state and datapath updates; priority clear > enter > digit_valid
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        buf_d      = buf_q;
        count_d    = count_q;
        attempts_d = attempts_q;
        tmr_d      = tmr_q;
        match_d    = match_q;
        case (state_q)
            S_ENTRY: begin
                if (clear) begin
                    count_d = '0;
                end else if (enter) begin
                    match_d = full_c && (buf_q == code_q);
                    state_d = S_CHECK;
                end else if (digit_valid && !full_c) begin
                    buf_d   = buf_wr;
                    count_d = count_q + DC_W'(1);
                end
            end
            S_CHECK: begin
                count_d = '0;
                tmr_d   = '0;
                if (match_q) begin
                    attempts_d = AT_W'(MAX_ATTEMPTS);
                    state_d    = S_UNLOCKED;
                end else begin
                    attempts_d = attempts_q - AT_W'(1);
                    state_d    = (attempts_q == AT_W'(1)) ? S_LOCKOUT : S_ENTRY;
                end
            end
            S_UNLOCKED: begin
                if (clear) begin
                    state_d = S_ENTRY;
                end else if (set_req) begin
                    count_d = '0;
                    state_d = S_PROGRAM;
                end else if (tmr_q == TMR_W'(UNLOCK_CYCLES - 1)) begin
                    state_d = S_ENTRY;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_LOCKOUT: begin
                if (tmr_q == TMR_W'(LOCKOUT_CYCLES - 1)) begin
                    attempts_d = AT_W'(MAX_ATTEMPTS);
                    state_d    = S_ENTRY;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_PROGRAM: begin
                if (clear) begin
                    count_d = '0;
                end else if (enter) begin
                    // A short count aborts without touching the stored code
                    if (full_c) begin
                        code_d = buf_q;
                    end
                    count_d = '0;
                    state_d = S_ENTRY;
                end else if (digit_valid && !full_c) begin
                    buf_d   = buf_wr;
                    count_d = count_q + DC_W'(1);
                end
            end
            default: begin
                count_d = '0;
                state_d = S_ENTRY;
            end
        endcase
    end

    // Output decode, registered one edge later alongside the state
    always_comb begin
        unlocked_d    = 1'b0;
        locked_out_d  = 1'b0;
        programming_d = 1'b0;
        fail_d        = 1'b0;
        prog_done_d   = 1'b0;
        unlocked_d    = (state_d == S_UNLOCKED);
        locked_out_d  = (state_d == S_LOCKOUT);
        programming_d = (state_d == S_PROGRAM);
        fail_d        = (state_q == S_CHECK) && !match_q;
        prog_done_d   = (state_q == S_PROGRAM) && !clear && enter && full_c;
    end

endmodule

// File: tb/tb_app_lock_controller.sv
// Directed bench for app_lock_controller: unlock, lockout, short/long entry,
// reprogramming, abort, reset during PROGRAM and input priority.
module tb_app_lock_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] digit_in = '0;
    logic       digit_valid = 1'b0;
    logic       enter = 1'b0;
    logic       clear = 1'b0;
    logic       set_req = 1'b0;
    logic       unlocked, locked_out, programming, fail, prog_done;
    logic [1:0] attempts_left;
    logic [2:0] digit_count;

    int n_cmp = 0;
    int n_err = 0;

    app_lock_controller dut (
        .clk          (clk),
        .reset        (reset),
        .digit_in     (digit_in),
        .digit_valid  (digit_valid),
        .enter        (enter),
        .clear        (clear),
        .set_req      (set_req),
        .unlocked     (unlocked),
        .locked_out   (locked_out),
        .programming  (programming),
        .fail         (fail),
        .prog_done    (prog_done),
        .attempts_left(attempts_left),
        .digit_count  (digit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_digit(input logic [3:0] d);
        digit_in    = d;
        digit_valid = 1'b1;
        step();
        digit_valid = 1'b0;
    endtask

    task automatic press_enter();
        enter = 1'b1;
        step();
        enter = 1'b0;
    endtask

    // Four digits, enter, then one more edge so the check result is visible
    task automatic try_code(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
        put_digit(a);
        put_digit(b);
        put_digit(c);
        put_digit(d);
        press_enter();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit bad;

        // Reset values
        #2 reset = 1'b0;
        #2;
        check("rst_unlocked", unlocked, 0);
        check("rst_locked_out", locked_out, 0);
        check("rst_programming", programming, 0);
        check("rst_fail", fail, 0);
        check("rst_prog_done", prog_done, 0);
        check("rst_attempts", attempts_left, 3);
        check("rst_count", digit_count, 0);
        step();
        reset = 1'b1;
        step();

        // Correct code unlocks two cycles after enter and holds for 8 cycles
        put_digit(4'd5);
        check("count_1", digit_count, 1);
        put_digit(4'd6);
        put_digit(4'd7);
        put_digit(4'd8);
        check("count_4", digit_count, 4);
        press_enter();
        check("unlock_not_yet", unlocked, 0);
        step();
        check("unlock_rise", unlocked, 1);
        check("unlock_attempts", attempts_left, 3);
        check("unlock_count_clr", digit_count, 0);
        n = 0;
        while (unlocked && n < 40) begin
            n++;
            step();
        end
        check("unlock_hold_len", n, 8);
        check("unlock_attempts_after", attempts_left, 3);

        // Three wrong codes lead to lockout
        try_code(4'd1, 4'd2, 4'd3, 4'd4);
        check("wrong1_fail", fail, 1);
        check("wrong1_attempts", attempts_left, 2);
        step();
        check("fail_one_cycle", fail, 0);
        try_code(4'd1, 4'd2, 4'd3, 4'd4);
        check("wrong2_fail", fail, 1);
        check("wrong2_attempts", attempts_left, 1);
        try_code(4'd1, 4'd2, 4'd3, 4'd4);
        check("wrong3_fail", fail, 1);
        check("wrong3_attempts", attempts_left, 0);
        check("lockout_rise", locked_out, 1);
        n = 0;
        bad = 1'b0;
        while (locked_out && n < 40) begin
            digit_in    = 4'd5;
            digit_valid = 1'b1;
            enter       = n[0];
            n++;
            step();
            if (digit_count != 3'd0 || fail || unlocked) bad = 1'b1;
        end
        digit_valid = 1'b0;
        enter       = 1'b0;
        check("lockout_len", n, 16);
        check("lockout_inputs_ignored", bad, 0);
        check("lockout_attempts_reload", attempts_left, 3);

        // Short entry fails; extra fifth digit is ignored
        put_digit(4'd5);
        put_digit(4'd6);
        press_enter();
        step();
        check("short_fail", fail, 1);
        check("short_unlocked", unlocked, 0);
        check("short_attempts", attempts_left, 2);
        put_digit(4'd5);
        put_digit(4'd6);
        put_digit(4'd7);
        put_digit(4'd8);
        put_digit(4'd9);
        check("extra_digit_count", digit_count, 4);
        press_enter();
        step();
        check("extra_digit_unlock", unlocked, 1);
        check("extra_digit_attempts", attempts_left, 3);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_relocks", unlocked, 0);

        // Clear discards partial entry
        put_digit(4'd5);
        put_digit(4'd6);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_count", digit_count, 0);
        try_code(4'd7, 4'd8, 4'd5, 4'd6);
        check("after_clear_fail", fail, 1);
        check("after_clear_attempts", attempts_left, 2);

        // Reprogram to 1,2,3,4
        try_code(4'd5, 4'd6, 4'd7, 4'd8);
        check("prog_pre_unlock", unlocked, 1);
        set_req = 1'b1;
        step();
        set_req = 1'b0;
        check("prog_enter", programming, 1);
        check("prog_unlocked_drop", unlocked, 0);
        check("prog_count", digit_count, 0);
        put_digit(4'd1);
        put_digit(4'd2);
        put_digit(4'd3);
        put_digit(4'd4);
        press_enter();
        check("prog_done_pulse", prog_done, 1);
        check("prog_exit", programming, 0);
        step();
        check("prog_done_one_cycle", prog_done, 0);
        try_code(4'd5, 4'd6, 4'd7, 4'd8);
        check("old_code_fails", fail, 1);
        try_code(4'd1, 4'd2, 4'd3, 4'd4);
        check("new_code_unlocks", unlocked, 1);

        // Reset in the middle of PROGRAM restores the default code
        set_req = 1'b1;
        step();
        set_req = 1'b0;
        put_digit(4'd9);
        put_digit(4'd9);
        #2 reset = 1'b0;
        #1;
        check("midprog_rst_programming", programming, 0);
        check("midprog_rst_count", digit_count, 0);
        check("midprog_rst_unlocked", unlocked, 0);
        step();
        reset = 1'b1;
        step();
        try_code(4'd5, 4'd6, 4'd7, 4'd8);
        check("default_restored", unlocked, 1);

        // Short commit aborts and leaves the code unchanged
        set_req = 1'b1;
        step();
        set_req = 1'b0;
        put_digit(4'd9);
        put_digit(4'd9);
        press_enter();
        check("abort_no_prog_done", prog_done, 0);
        check("abort_exit", programming, 0);
        try_code(4'd5, 4'd6, 4'd7, 4'd8);
        check("abort_code_kept", unlocked, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;

        // clear beats digit_valid in the same cycle
        put_digit(4'd1);
        put_digit(4'd2);
        check("prio_count_2", digit_count, 2);
        digit_in    = 4'd3;
        digit_valid = 1'b1;
        clear       = 1'b1;
        step();
        digit_valid = 1'b0;
        clear       = 1'b0;
        check("prio_clear_count", digit_count, 0);

        // enter with the last digit: that digit is not stored, so the check fails
        put_digit(4'd5);
        put_digit(4'd6);
        put_digit(4'd7);
        digit_in    = 4'd8;
        digit_valid = 1'b1;
        enter       = 1'b1;
        step();
        digit_valid = 1'b0;
        enter       = 1'b0;
        check("prio_enter_count", digit_count, 3);
        step();
        check("prio_enter_fail", fail, 1);
        check("prio_enter_unlocked", unlocked, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
